// File: rtl/pic_command_sequencer_pkg.sv
// pic_pkg: shared types for the 8259 write-side command sequencer.
// Holds the init state enum, OCW2 command codes, field bit positions
// and the packed configuration bundle held by the sequencer.
package pic_pkg;

    typedef enum logic [2:0] {
        UNINIT,
        ICW2,
        ICW3,
        ICW4,
        READY
    } pic_state_t;

    // OCW2 {R,SL,EOI} command codes
    localparam logic [2:0] ROT_AEOI_CLR = 3'b000;
    localparam logic [2:0] NS_EOI       = 3'b001;
    localparam logic [2:0] SP_EOI       = 3'b011;
    localparam logic [2:0] ROT_AEOI_SET = 3'b100;
    localparam logic [2:0] ROT_NS_EOI   = 3'b101;
    localparam logic [2:0] SET_PRIO     = 3'b110;
    localparam logic [2:0] ROT_SP_EOI   = 3'b111;

    // ICW1 fields
    localparam int unsigned ICW1_IC4  = 0;
    localparam int unsigned ICW1_SNGL = 1;
    localparam int unsigned ICW1_LTIM = 3;
    localparam int unsigned ICW1_SEL  = 4;

    // ICW4 fields
    localparam int unsigned ICW4_UPM  = 0;
    localparam int unsigned ICW4_AEOI = 1;
    localparam int unsigned ICW4_MS   = 2;
    localparam int unsigned ICW4_BUF  = 3;
    localparam int unsigned ICW4_SFNM = 4;

    // OCW2/OCW3 select and OCW3 fields
    localparam int unsigned OCW_SEL   = 3;
    localparam int unsigned OCW3_RIS  = 0;
    localparam int unsigned OCW3_RR   = 1;
    localparam int unsigned OCW3_P    = 2;
    localparam int unsigned OCW3_SMM  = 5;
    localparam int unsigned OCW3_ESMM = 6;

    typedef struct packed {
        logic       ltim;
        logic       sngl;
        logic       ic4;
        logic [4:0] vec_base;
        logic       upm;
        logic       aeoi;
        logic       ms;
        logic       buf_mode;
        logic       sfnm;
        logic [7:0] imr;
        logic       rotate_aeoi;
        logic       smm;
        logic       read_isr;
        logic       eoi_valid;
        logic [2:0] eoi_cmd;
        logic [2:0] eoi_level;
        logic       poll_req;
    } pic_cfg_t;

endpackage

// File: rtl/pic_command_sequencer_write_strobe.sv
// pic_write_strobe: registers wr, captures a0/din while wr is high and
// flags the commit edge (trailing edge of the write: wr_q=1, wr=0).
// Ports: clk, reset (async high), wr, a0, din in;
//        commit, wr_a0, wr_din out (captured write, valid with commit).
module pic_write_strobe (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr,
    input  logic       a0,
    input  logic [7:0] din,
    output logic       commit,
    output logic       wr_a0,
    output logic [7:0] wr_din
);

    logic wr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q   <= 1'b0;
            wr_a0  <= 1'b0;
            wr_din <= 8'h00;
        end else begin
            wr_q <= wr;
            if (wr) begin
                wr_a0  <= a0;
                wr_din <= din;
            end
        end
    end

    // A write held high never commits; only its falling edge does.
    assign commit = wr_q & ~wr;

endmodule

// File: rtl/pic_command_sequencer.sv
// pic_command_sequencer: 8259 write-side control. Runs ICW1..ICW4 init
// then decodes OCW1/2/3, holding all programmed configuration.
// Ports: clk, reset, wr, a0, din in; init_done, ICW fields, imr,
// rotate_aeoi, eoi_valid/cmd/level, smm, read_isr, poll_req out.
// Macro PIC_CASCADE_EN: enables the ICW3 state and icw3 register.
import pic_pkg::*;

module pic_command_sequencer #(
    parameter logic [7:0] IMR_INIT  = 8'h00,
    parameter logic [4:0] VEC_RESET = 5'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr,
    input  logic       a0,
    input  logic [7:0] din,
    output logic       init_done,
    output logic       ltim,
    output logic       sngl,
    output logic [4:0] vec_base,
    output logic [7:0] icw3,
    output logic       aeoi,
    output logic       ms,
    output logic       buf_mode,
    output logic       sfnm,
    output logic       upm,
    output logic [7:0] imr,
    output logic       rotate_aeoi,
    output logic       eoi_valid,
    output logic [2:0] eoi_cmd,
    output logic [2:0] eoi_level,
    output logic       smm,
    output logic       read_isr,
    output logic       poll_req
);

    logic       commit;
    logic       wa0;
    logic [7:0] wdin;

    pic_state_t state, state_n;
    pic_cfg_t   cfg, cfg_n;

    function automatic pic_cfg_t cfg_reset();
        pic_cfg_t c;
        c          = '0;
        c.imr      = IMR_INIT;
        c.vec_base = VEC_RESET;
        return c;
    endfunction

    pic_write_strobe u_strobe (
        .clk    (clk),
        .reset  (reset),
        .wr     (wr),
        .a0     (a0),
        .din    (din),
        .commit (commit),
        .wr_a0  (wa0),
        .wr_din (wdin)
    );

`ifdef PIC_CASCADE_EN
    logic [7:0] icw3_q, icw3_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) icw3_q <= 8'h00;
        else       icw3_q <= icw3_n;
    end

    assign icw3 = icw3_q;
`else
    assign icw3 = 8'h00;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= UNINIT;
            cfg   <= cfg_reset();
        end else begin
            state <= state_n;
            cfg   <= cfg_n;
        end
    end

    always_comb begin
        state_n         = state;
        cfg_n           = cfg;
        cfg_n.eoi_valid = 1'b0;
        cfg_n.poll_req  = 1'b0;
`ifdef PIC_CASCADE_EN
        icw3_n          = icw3_q;
`endif
        if (commit) begin
            if (!wa0 && wdin[ICW1_SEL]) begin
                // ICW1 restarts init from any state
                cfg_n.ltim        = wdin[ICW1_LTIM];
                cfg_n.sngl        = wdin[ICW1_SNGL];
                cfg_n.ic4         = wdin[ICW1_IC4];
                cfg_n.imr         = IMR_INIT;
                cfg_n.smm         = 1'b0;
                cfg_n.read_isr    = 1'b0;
                cfg_n.rotate_aeoi = 1'b0;
                cfg_n.upm         = 1'b0;
                cfg_n.aeoi        = 1'b0;
                cfg_n.ms          = 1'b0;
                cfg_n.buf_mode    = 1'b0;
                cfg_n.sfnm        = 1'b0;
                state_n           = ICW2;
            end else begin
                case (state)
                    ICW2: if (wa0) begin
                        cfg_n.vec_base = wdin[7:3];
`ifdef PIC_CASCADE_EN
                        if (!cfg.sngl)
                            state_n = ICW3;
                        else
                            state_n = cfg.ic4 ? ICW4 : READY;
`else
                        state_n = cfg.ic4 ? ICW4 : READY;
`endif
                    end
`ifdef PIC_CASCADE_EN
                    ICW3: if (wa0) begin
                        icw3_n  = wdin;
                        state_n = cfg.ic4 ? ICW4 : READY;
                    end
`endif
                    ICW4: if (wa0) begin
                        cfg_n.upm      = wdin[ICW4_UPM];
                        cfg_n.aeoi     = wdin[ICW4_AEOI];
                        cfg_n.ms       = wdin[ICW4_MS];
                        cfg_n.buf_mode = wdin[ICW4_BUF];
                        cfg_n.sfnm     = wdin[ICW4_SFNM];
                        state_n        = READY;
                    end
                    READY: begin
                        unique case (1'b1)
                            wa0: cfg_n.imr = wdin;
                            (!wa0 && !wdin[OCW_SEL]): begin
                                cfg_n.eoi_valid = 1'b1;
                                cfg_n.eoi_cmd   = wdin[7:5];
                                cfg_n.eoi_level = wdin[2:0];
                                if (wdin[7:5] == ROT_AEOI_SET)
                                    cfg_n.rotate_aeoi = 1'b1;
                                else if (wdin[7:5] == ROT_AEOI_CLR)
                                    cfg_n.rotate_aeoi = 1'b0;
                            end
                            (!wa0 && wdin[OCW_SEL]): begin
                                if (wdin[OCW3_ESMM])
                                    cfg_n.smm = wdin[OCW3_SMM];
                                if (wdin[OCW3_RR])
                                    cfg_n.read_isr = wdin[OCW3_RIS];
                                cfg_n.poll_req = wdin[OCW3_P];
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

    assign init_done   = (state == READY);
    assign ltim        = cfg.ltim;
    assign sngl        = cfg.sngl;
    assign vec_base    = cfg.vec_base;
    assign aeoi        = cfg.aeoi;
    assign ms          = cfg.ms;
    assign buf_mode    = cfg.buf_mode;
    assign sfnm        = cfg.sfnm;
    assign upm         = cfg.upm;
    assign imr         = cfg.imr;
    assign rotate_aeoi = cfg.rotate_aeoi;
    assign eoi_valid   = cfg.eoi_valid;
    assign eoi_cmd     = cfg.eoi_cmd;
    assign eoi_level   = cfg.eoi_level;
    assign smm         = cfg.smm;
    assign read_isr    = cfg.read_isr;
    assign poll_req    = cfg.poll_req;

endmodule

// File: doc/pic_command_sequencer.md
Name: pic_command_sequencer

Overview:
- Write-side control block of the 8259 PIC.
- Watches the write strobe from the read/write logic, together with A0 and the internal data bus.
- Runs the ICW1→ICW2→(ICW3)→(ICW4) initialization sequence, then decodes OCW1/OCW2/OCW3.
- Holds every programmed configuration register consumed by the priority resolver, IMR/ISR logic, cascade logic and read mux.

Parameters:
- IMR_INIT, 8'h00: IMR value loaded at reset and on every ICW1.
- VEC_RESET, 5'h00: vector base T7..T3 value at reset.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- wr  in  1  active-high write enable from Read_Write_Logic (already CS-qualified), synchronous to clk
- a0  in  1  address bit A0
- din  in  8  internal data bus
- init_done  out  1  high in READY state
- ltim  out  1  ICW1 D3, level-triggered mode
- sngl  out  1  ICW1 D1, single mode
- vec_base  out  5  ICW2 D7..D3
- icw3  out  8  cascade word
- aeoi  out  1  ICW4 D1
- ms  out  1  ICW4 D2
- buf_mode  out  1  ICW4 D3
- sfnm  out  1  ICW4 D4
- upm  out  1  ICW4 D0
- imr  out  8  interrupt mask (OCW1)
- rotate_aeoi  out  1  rotate-on-AEOI flag
- eoi_valid  out  1  one-cycle pulse, OCW2 command issued
- eoi_cmd  out  3  OCW2 {R,SL,EOI}
- eoi_level  out  3  OCW2 L2..L0
- smm  out  1  special mask mode
- read_isr  out  1  0 = IRR selected for read, 1 = ISR
- poll_req  out  1  one-cycle pulse, OCW3 P=1

Behaviour:
- Write capture:
  - While wr=1, a0/din are registered every cycle.
  - wr_q holds wr delayed one cycle.
  - Commit edge: the clk edge where wr_q=1 and wr=0 (trailing edge of the write).
  - All register updates and pulses occur at the commit edge. Pulses are high exactly one cycle.
  - At most one command per wr assertion. wr held high indefinitely produces no commit.
- Reset (asynchronous):
  - state=UNINIT.
  - imr=IMR_INIT, vec_base=VEC_RESET.
  - All other outputs 0: init_done, pulses, icw3, ICW4 fields, ltim, sngl, rotate_aeoi, smm, read_isr.
- ICW1 = a0=0 and din[4]=1:
  - Accepted in ANY state, including mid-sequence (restarts the sequence).
  - Latches ltim=din[3], sngl=din[1], ic4=din[0].
  - Sets imr=IMR_INIT, smm=0, read_isr=0, rotate_aeoi=0.
  - Clears aeoi/ms/buf_mode/sfnm/upm.
  - init_done=0. Next state: ICW2.
- ICW2 state:
  - a0=1 write: vec_base=din[7:3]. Next state: ICW3 if sngl=0, else ICW4 if ic4=1, else READY.
  - a0=0 non-ICW1 write is ignored; state is held.
- ICW3 state:
  - a0=1: icw3=din. Next state: ICW4 if ic4=1, else READY.
- ICW4 state:
  - a0=1: upm=din[0], aeoi=din[1], ms=din[2], buf_mode=din[3], sfnm=din[4]. Next state: READY.
- READY (init_done=1):
  - a0=1 → OCW1: imr=din.
  - a0=0, din[4:3]=00 → OCW2:
    - eoi_valid=1, eoi_cmd=din[7:5], eoi_level=din[2:0].
    - Additionally, cmd 3'b100 sets rotate_aeoi and cmd 3'b000 clears it; for these two, eoi_valid is still pulsed.
  - a0=0, din[4:3]=01 → OCW3:
    - If din[6]=1 (ESMM): smm=din[5].
    - If din[1]=1 (RR): read_isr=din[0].
    - poll_req=din[2].
- UNINIT: every write except ICW1 is ignored.
- Reset asserted mid-write: no commit occurs, and wr_q is cleared.

Optional Feature:
- PIC_CASCADE_EN defined: ICW3 state is present as described.
- Not defined:
  - ICW3 state and the icw3 register are removed; icw3 is tied to 8'h00.
  - ICW2 goes to ICW4 or READY regardless of sngl. sngl is still latched and reported.

Decomposition:
- Package pic_pkg holds:
  - state enum UNINIT/ICW2/ICW3/ICW4/READY;
  - OCW2 command localparams (NS_EOI=3'b001, SP_EOI=3'b011, ROT_NS_EOI=3'b101, ROT_AEOI_SET=3'b100, ROT_AEOI_CLR=3'b000, SET_PRIO=3'b110, ROT_SP_EOI=3'b111);
  - field bit positions.
- One natural sub-module: pic_write_strobe, which does wr registration, a0/din capture and the commit pulse.

Test Plan:
- Reset → imr=8'h00, init_done=0. Write a0=1 din=8'hFF in UNINIT → imr stays 8'h00.
- ICW1=8'h13 (single, IC4), ICW2=8'h20, ICW4=8'h01 → vec_base=5'h04, upm=1, sngl=1, init_done=1 one cycle after the third commit.
- With PIC_CASCADE_EN: ICW1=8'h11, ICW2=8'h08, ICW3=8'h04, ICW4=8'h03 → icw3=8'h04, aeoi=1. Without the macro the same writes leave icw3=8'h00 and treat 8'h04 as ICW4 (aeoi=0, ms=1).
- READY: OCW1 8'hA5 → imr=8'hA5. OCW2 8'h63 → eoi_valid pulse for 1 cycle, eoi_cmd=3'b011, eoi_level=3'd3. OCW2 8'h80 → rotate_aeoi=1.
- OCW3 8'h0B → read_isr=1. OCW3 8'h68 → smm=1. OCW3 8'h0C → poll_req pulse, read_isr unchanged.
- ICW1 8'h13 issued after ICW2 mid-sequence → state returns to ICW2, imr=IMR_INIT. Async reset asserted while wr=1 → no commit, all outputs at reset values.
